// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, forwarding selects and hazard FSM encoding
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LU_STALL = 2'd1,
        BR_FLUSH = 2'd2
    } hz_state_e;

    // Instructions that read rt as a source operand (R-type, branches, store data).
    function automatic logic uses_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
               (opcode == OP_BNE)   || (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-low reset
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use stall, branch/jump flush and EX forwarding control
module hazard_unit
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [5:0]       opcode_ID,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic [4:0]       rs_EX,
    input  logic [4:0]       rt_EX,
    input  logic [4:0]       rd_EX,
    input  logic             MEM2REG_EX,
    input  logic             Write_EN_EX,
    input  logic [4:0]       rd_MEM,
    input  logic             Write_EN_MEM,
    input  logic [4:0]       rd_WB,
    input  logic             Write_EN_WB,
    input  logic             J_ID,
    input  logic             BrTaken_EX,
    output logic             Stall,
    output logic             Flush_IFID,
    output logic             Flush_IDEX,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_e state_q;
    hz_state_e state_d;
    logic      lu;

    assign lu = MEM2REG_EX && Write_EN_EX && (rd_EX != 5'd0) &&
                ((rd_EX == rs_ID) || ((rd_EX == rt_ID) && uses_rt(opcode_ID)));

    // Taken branch outranks lu and J_ID: both belong to wrong-path slots.
    always_comb begin
        state_d    = IDLE;
        Stall      = 1'b0;
        Flush_IFID = 1'b0;
        Flush_IDEX = 1'b0;
        if (RST_N) begin
            case (state_q)
                IDLE: begin
                    if (BrTaken_EX) begin
                        Flush_IFID = 1'b1;
                        Flush_IDEX = 1'b1;
                        state_d    = BR_FLUSH;
                    end else if (lu) begin
                        Stall   = 1'b1;
                        state_d = LU_STALL;
                    end else if (J_ID) begin
                        Flush_IFID = 1'b1;
                    end
                end
                LU_STALL: begin
                    if (BrTaken_EX) begin
                        Flush_IFID = 1'b1;
                        Flush_IDEX = 1'b1;
                        state_d    = BR_FLUSH;
                    end else if (J_ID) begin
                        Flush_IFID = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ForwardA = FWD_RF;
        ForwardB = FWD_RF;
        if (RST_N) begin
            if (Write_EN_MEM && (rd_MEM != 5'd0) && (rd_MEM == rs_EX)) begin
                ForwardA = FWD_MEM;
            end else if (Write_EN_WB && (rd_WB != 5'd0) && (rd_WB == rs_EX)) begin
                ForwardA = FWD_WB;
            end
            if (Write_EN_MEM && (rd_MEM != 5'd0) && (rd_MEM == rt_EX)) begin
                ForwardB = FWD_MEM;
            end else if (Write_EN_WB && (rd_WB != 5'd0) && (rd_WB == rt_EX)) begin
                ForwardB = FWD_WB;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (Stall),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (Flush_IFID | Flush_IDEX),
        .q     (flush_cnt)
    );

endmodule
